flag_unit: RTL

FLAG_UNIT -- requirements
Module: flag_unit

---
 rtl/flag_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - status flag register {S,Z,C,V} with optional 4-deep flag stack (FLAG_STACK_EN)
module flag_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_we,
  input  logic [2:0]  alu_op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] result,
  input  logic        shift_out,
  input  logic        push,
  input  logic        pop,
  input  logic        err_clr,
  output logic [3:0]  FLAG,
  output logic        stk_full,
  output logic        stk_empty,
  output logic        flag_err
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_CMP   = 3'b010;
  localparam logic [2:0] OP_LOGIC = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_MOVE  = 3'b101;
  localparam logic [2:0] OP_SETF  = 3'b110;

  logic [3:0]  flag_q;
  logic [3:0]  flag_d;
  logic [3:0]  alu_flags;
  logic [16:0] sum;
  logic [15:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  // Flag value the current alu_op would produce, bits ordered {S,Z,C,V}
  always_comb begin
    alu_flags = flag_q;
    case (alu_op)
      OP_ADD: alu_flags = {sum[15], (sum[15:0] == 16'd0), sum[16],
                           (a[15] == b[15]) && (sum[15] != a[15])};
      OP_SUB,
      OP_CMP: alu_flags = {diff[15], (diff == 16'd0), (a < b),
                           (a[15] != b[15]) && (diff[15] != a[15])};
      OP_LOGIC: alu_flags = {result[15], (result == 16'd0), 1'b0, 1'b0};
      OP_SHIFT: alu_flags = {result[15], (result == 16'd0), shift_out, 1'b0};
      OP_MOVE:  alu_flags = {result[15], (result == 16'd0), flag_q[1:0]};
      OP_SETF:  alu_flags = b[3:0];
      default:  alu_flags = flag_q;
    endcase
  end

`ifdef FLAG_STACK_EN
  logic [3:0] stk_q [0:3];
  logic [2:0] depth_q;
  logic [2:0] depth_d;
  logic       err_q;
  logic       err_d;
  logic       empty_q;
  logic       full_q;
  logic       push_ok;
  logic       pop_ok;
  logic       err_evt;
  logic [1:0] wr_idx;
  logic [1:0] rd_idx;

  assign push_ok = push && !pop && (depth_q != 3'd4);
  assign pop_ok  = pop && !push && (depth_q != 3'd0);
  assign err_evt = (push && pop) ||
                   (push && !pop && (depth_q == 3'd4)) ||
                   (pop && !push && (depth_q == 3'd0));
  // depth 1..4 wraps to 1,2,3,0 in two bits, so minus one lands on 0..3
  assign wr_idx  = depth_q[1:0];
  assign rd_idx  = depth_q[1:0] - 2'd1;

  // Next flag/depth/error: a restore wins over the ALU, any pop blocks the ALU write
  always_comb begin
    flag_d  = flag_q;
    depth_d = depth_q;
    err_d   = err_q;
    if (pop_ok) begin
      flag_d  = stk_q[rd_idx];
      depth_d = depth_q - 3'd1;
    end else if (flag_we && !pop) begin
      flag_d = alu_flags;
    end
    if (push_ok) begin
      depth_d = depth_q + 3'd1;
    end
    if (err_evt) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Stack storage holds the pre-update FLAG; contents need no reset
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      stk_q[wr_idx] <= flag_q;
    end
  end

  // Flag, depth and registered stack status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q  <= 4'b0000;
      depth_q <= 3'd0;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      empty_q <= (depth_d == 3'd0);
      full_q  <= (depth_d == 3'd4);
    end
  end

  assign stk_empty = empty_q;
  assign stk_full  = full_q;
  assign flag_err  = err_q;
`else
  logic unused_stack_inputs;
  assign unused_stack_inputs = ^{push, pop, err_clr};

  // Without the stack only the ALU write can change FLAG
  always_comb begin
    flag_d = flag_q;
    if (flag_we) begin
      flag_d = alu_flags;
    end
  end

  // Flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 4'b0000;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign stk_empty = 1'b1;
  assign stk_full  = 1'b0;
  assign flag_err  = 1'b0;
`endif

  assign FLAG = flag_q;

endmodule
